// File: rtl/buffer_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the FIFO write-port arbiter.
// The two-bit state values are fixed so that the debug state output is stable.
package buffer_write_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_CH_BITS    = 2;
    localparam int DEF_RETRY_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/buffer_write_arbiter_rr_select.sv
// Combinational round-robin picker: the first requesting channel above last_ch,
// wrapping modulo NUM_CH. This means last_ch itself is only chosen when it is the sole requester.
module rr_select #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2
) (
    input  logic [NUM_CH-1:0]  req_valid,
    input  logic [CH_BITS-1:0] last_ch,
    output logic               any,
    output logic [CH_BITS-1:0] sel_ch
);

    int idx;

    always_comb begin
        any    = 1'b0;
        sel_ch = '0;
        idx    = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(last_ch) + i) % NUM_CH;
            if (!any && req_valid[idx]) begin
                any    = 1'b1;
                sel_ch = CH_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/buffer_write_arbiter.sv
// Round-robin arbiter that shares the sample FIFO write port between NUM_CH producers.
// Each attempt is a one-cycle valid pulse. A refused attempt is retried, so every word is stored exactly once.
module buffer_write_arbiter
    import buffer_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CH_BITS    = DEF_CH_BITS,
    parameter int RETRY_W    = DEF_RETRY_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]        buf_data_in,
    output logic                         buf_data_in_valid,
    input  logic                         buf_data_in_ack,
    output logic [CH_BITS-1:0]           grant_ch,
    output logic                         busy,
    output logic [RETRY_W-1:0]           retry_cnt,
    output arb_state_t                   dbg_state
);

    // Handshake: the FIFO stores a word at any edge where buf_data_in_valid is high and it
    // is neither reading nor full, then raises buf_data_in_ack for exactly the next cycle.
    // Because of this, valid is a one-cycle pulse and the ack is sampled in CHECK.
    // The requester holds req_valid until req_ack, which is a one-cycle pulse in DONE.

    arb_state_t              state_q, state_d;
    logic [CH_BITS-1:0]      grant_q, grant_d;
    logic [CH_BITS-1:0]      last_q, last_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic [NUM_CH-1:0]       ack_q, ack_d;
    logic [RETRY_W-1:0]      retry_q, retry_d;

    logic                    any_req;
    logic [CH_BITS-1:0]      sel_ch;
    logic [DATA_WIDTH-1:0]   sel_data;

    rr_select #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_rr_select (
        .req_valid (req_valid),
        .last_ch   (last_q),
        .any       (any_req),
        .sel_ch    (sel_ch)
    );

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_BITS'(k) == sel_ch) sel_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ack_d   = '0;
        retry_d = retry_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = sel_ch;
                    data_d  = sel_data;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (buf_data_in_ack) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (CH_BITS'(k) == grant_q) ack_d[k] = 1'b1;
                    end
                    last_d  = grant_q;
                    state_d = DONE;
                end else begin
                    // Refused: resend the same latched word; the counter sticks at all-ones.
                    if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= CH_BITS'(NUM_CH - 1);
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            retry_q <= retry_d;
        end
    end

    assign req_ack           = ack_q;
    assign buf_data_in       = data_q;
    assign buf_data_in_valid = valid_q;
    assign grant_ch          = grant_q;
    assign busy              = (state_q != IDLE);
    assign retry_cnt         = retry_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Self-checking bench for buffer_write_arbiter: directed sequences, a vector table and
// randomized traffic against a round-robin queue model, driven by a behavioural FIFO.
module tb_buffer_write_arbiter;
    import buffer_write_arbiter_pkg::*;

    localparam int DW    = 8;
    localparam int NCH   = 4;
    localparam int CHB   = 2;
    localparam int RW    = 8;
    localparam int DEPTH = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ack;
    logic [DW-1:0]     buf_data_in;
    logic              buf_data_in_valid;
    logic              buf_data_in_ack;
    logic [CHB-1:0]    grant_ch;
    logic              busy;
    logic [RW-1:0]     retry_cnt;
    arb_state_t        dbg_state;

    buffer_write_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .CH_BITS    (CHB),
        .RETRY_W    (RW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_data          (req_data),
        .req_valid         (req_valid),
        .req_ack           (req_ack),
        .buf_data_in       (buf_data_in),
        .buf_data_in_valid (buf_data_in_valid),
        .buf_data_in_ack   (buf_data_in_ack),
        .grant_ch          (grant_ch),
        .busy              (busy),
        .retry_cnt         (retry_cnt),
        .dbg_state         (dbg_state)
    );

    // behavioural FIFO write side: read has priority, ack registered
    logic          fifo_read = 1'b0;
    logic          fifo_fill = 1'b0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] wr_log[$];
    int            refusals;
    logic          wr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q.delete();
            wr_log.delete();
            refusals = 0;
            buf_data_in_ack <= 1'b0;
        end else begin
            wr = buf_data_in_valid && !fifo_read && (fifo_q.size() < DEPTH);
            if (buf_data_in_valid && !wr) refusals++;
            if (fifo_read && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (fifo_fill && fifo_q.size() < DEPTH) fifo_q.push_back(8'hE0 + 8'(fifo_q.size()));
            if (wr) begin
                fifo_q.push_back(buf_data_in);
                wr_log.push_back(buf_data_in);
            end
            buf_data_in_ack <= wr;
        end
    end

    // scoreboard bookkeeping
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;
    logic [DW-1:0] exp_q[$];
    int   exp_ch_q[$];
    int   ack_exp_q[$];
    int   rd_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one cycle; every cycle also checks the pulse invariants
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (buf_data_in_valid) check("valid_single_cycle", 32'(prev_valid), 32'd0);
            if (req_ack != '0) begin
                check("ack_onehot", $countones(req_ack), 32'd1);
                check("ack_in_done", 32'(dbg_state), 32'd3);
            end
            prev_valid = buf_data_in_valid;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_read = 1'b0;
        fifo_fill = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        prev_valid = 1'b0;
        rd_idx     = 0;
    endtask

    task automatic wait_ack(input string name, input int limit);
        logic got;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (req_ack != '0) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_ack_seen"}, 32'(got), 32'd1);
    endtask

    task automatic fill_fifo();
        fifo_fill = 1'b1;
        repeat (DEPTH) tick();
        fifo_fill = 1'b0;
        check("fifo_prefill", fifo_q.size(), DEPTH);
    endtask

    typedef struct {
        int            prime;
        logic [NCH-1:0] mask;
        int            exp_ch;
        logic [DW-1:0] exp_word;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] got_w[$];
        int            got_c[$];
        logic          found;
        logic          ack_seen;
        int            cnt;
        logic [DW-1:0] words_q[NCH][$];
        int            take[NCH];
        int            last;
        logic          done;
        int            rd_pct;

        vecs[0] = '{1, 4'b1001, 3, 8'hC3};
        vecs[1] = '{3, 4'b1001, 0, 8'hC0};
        vecs[2] = '{0, 4'b0001, 0, 8'hC0};
        vecs[3] = '{2, 4'b1111, 3, 8'hC3};
        vecs[4] = '{3, 4'b0110, 1, 8'hC1};
        vecs[5] = '{1, 4'b0010, 1, 8'hC1};
        vecs[6] = '{0, 4'b1100, 2, 8'hC2};
        vecs[7] = '{2, 4'b0011, 0, 8'hC0};

        // reset state
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(buf_data_in_valid), 0);
        check("rst_ack", 32'(req_ack), 0);
        check("rst_grant", 32'(grant_ch), 0);
        check("rst_retry", 32'(retry_cnt), 0);
        check("rst_data", 32'(buf_data_in), 0);
        check("rst_state", 32'(dbg_state), 0);

        // single request from ch2, best-case timing
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'hA5;
        tick();
        check("t1_valid", 32'(buf_data_in_valid), 1);
        check("t1_data", 32'(buf_data_in), 32'hA5);
        check("t1_grant", 32'(grant_ch), 2);
        check("t1_busy", 32'(busy), 1);
        tick();
        check("t1_check_valid", 32'(buf_data_in_valid), 0);
        check("t1_check_ack", 32'(req_ack), 0);
        tick();
        check("t1_ack", 32'(req_ack), 32'b0100);
        req_valid = '0;
        tick();
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_ack_clear", 32'(req_ack), 0);
        check("t1_fifo_count", fifo_q.size(), 1);
        check("t1_fifo_word", 32'(fifo_q[0]), 32'hA5);
        check("t1_retry", 32'(retry_cnt), 0);

        // all channels requesting continuously
        do_reset();
        req_valid = 4'b1111;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (buf_data_in_valid) begin
                got_w.push_back(buf_data_in);
                got_c.push_back(c);
            end
        end
        check("t2_pulses", got_w.size(), 5);
        if (got_w.size() == 5) begin
            for (int i = 0; i < 5; i++) check("t2_word", 32'(got_w[i]), 32'h10 + 32'(i % 4));
            for (int i = 1; i < 5; i++) check("t2_spacing", got_c[i] - got_c[i-1], 4);
        end
        req_valid = '0;
        for (int i = 0; i < 20 && busy; i++) tick();
        check("t2_drained", 32'(busy), 0);

        // full FIFO: retries until a pop frees a slot
        do_reset();
        fill_fifo();
        req_valid = 4'b0010;
        req_data[1*DW +: DW] = 8'h3C;
        found = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req_ack != '0) ack_seen = 1'b1;
            if (retry_cnt == 8'd3 && buf_data_in_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_retry_reached_3", 32'(found), 1);
        check("t3_no_early_ack", 32'(ack_seen), 0);
        tick();
        check("t3_check_phase", 32'(buf_data_in_valid), 0);
        fifo_read = 1'b1;
        tick();
        fifo_read = 1'b0;
        wait_ack("t3", 10);
        check("t3_ack", 32'(req_ack), 32'b0010);
        check("t3_retry", 32'(retry_cnt), 4);
        req_valid = '0;
        tick();
        check("t3_fifo_count", fifo_q.size(), DEPTH);
        check("t3_fifo_last", 32'(fifo_q[DEPTH-1]), 32'h3C);
        cnt = 0;
        foreach (fifo_q[i]) if (fifo_q[i] == 8'h3C) cnt++;
        check("t3_single_copy", cnt, 1);

        // read priority during SEND causes exactly one retry
        do_reset();
        req_valid = 4'b0001;
        req_data[0 +: DW] = 8'h77;
        tick();
        check("t4_send", 32'(buf_data_in_valid), 1);
        fifo_read = 1'b1;
        tick();
        fifo_read = 1'b0;
        tick();
        check("t4_resend", 32'(buf_data_in_valid), 1);
        check("t4_retry", 32'(retry_cnt), 1);
        wait_ack("t4", 10);
        req_valid = '0;
        tick();
        check("t4_fifo_count", fifo_q.size(), 1);
        check("t4_fifo_word", 32'(fifo_q[0]), 32'h77);

        // asynchronous reset in the middle of SEND
        do_reset();
        req_valid = 4'b0010;
        req_data[1*DW +: DW] = 8'h55;
        tick();
        check("t5_send", 32'(buf_data_in_valid), 1);
        rst = 1'b1;
        #1;
        check("t5_async_valid", 32'(buf_data_in_valid), 0);
        check("t5_async_busy", 32'(busy), 0);
        check("t5_async_ack", 32'(req_ack), 0);
        req_valid = 4'b1001;
        req_data  = {8'h33, 8'h00, 8'h55, 8'h11};
        @(negedge clk);
        rst = 1'b0;
        prev_valid = 1'b0;
        tick();
        check("t5_grant_first", 32'(grant_ch), 0);
        check("t5_data_first", 32'(buf_data_in), 32'h11);
        wait_ack("t5", 10);
        check("t5_ack", 32'(req_ack), 32'b0001);
        req_valid = '0;
        tick();
        check("t5_writes", wr_log.size(), 1);

        // retry counter saturation
        do_reset();
        fill_fifo();
        req_valid = 4'b0100;
        ack_seen  = 1'b0;
        for (int i = 0; i < 620; i++) begin
            tick();
            if (req_ack != '0) ack_seen = 1'b1;
        end
        check("t6_refusals_300", 32'(refusals >= 300), 1);
        check("t6_saturated", 32'(retry_cnt), 255);
        check("t6_no_ack", 32'(ack_seen), 0);
        repeat (20) tick();
        check("t6_held", 32'(retry_cnt), 255);
        do_reset();
        check("t6_reset_clears", 32'(retry_cnt), 0);

        // round-robin vector table
        foreach (vecs[v]) begin
            do_reset();
            req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
            req_valid = NCH'(1) << vecs[v].prime;
            wait_ack("vec_prime", 10);
            req_valid = '0;
            tick();
            req_valid = vecs[v].mask;
            tick();
            check("vec_grant", 32'(grant_ch), 32'(vecs[v].exp_ch));
            check("vec_word", 32'(buf_data_in), 32'(vecs[v].exp_word));
            wait_ack("vec", 10);
            check("vec_ack", 32'(req_ack), 32'(NCH'(1) << vecs[v].exp_ch));
            req_valid = '0;
            tick();
        end

        // randomized traffic against a queue-level round-robin model
        do_reset();
        foreach (words_q[k]) begin
            words_q[k].delete();
            repeat ($urandom_range(0, 6)) words_q[k].push_back(8'($urandom));
            take[k] = 0;
        end
        exp_q.delete();
        exp_ch_q.delete();
        ack_exp_q.delete();
        last = NCH - 1;
        done = 1'b0;
        while (!done) begin
            done = 1'b1;
            for (int i = 1; i <= NCH; i++) begin
                int c;
                c = (last + i) % NCH;
                if (take[c] < words_q[c].size()) begin
                    exp_q.push_back(words_q[c][take[c]]);
                    exp_ch_q.push_back(c);
                    take[c]++;
                    last = c;
                    done = 1'b0;
                    break;
                end
            end
        end
        rd_pct = 30;
        for (int k = 0; k < NCH; k++) begin
            req_valid[k] = (words_q[k].size() > 0);
            req_data[k*DW +: DW] = (words_q[k].size() > 0) ? words_q[k][0] : '0;
        end
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc % 100 == 0) rd_pct = $urandom_range(0, 60);
            fifo_read = ($urandom_range(0, 99) < rd_pct);
            tick();
            while (rd_idx < wr_log.size()) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_write", 32'(wr_log[rd_idx]), 32'hFFFF_FFFF);
                end else begin
                    check("rnd_word", 32'(wr_log[rd_idx]), 32'(exp_q.pop_front()));
                    ack_exp_q.push_back(exp_ch_q.pop_front());
                end
                rd_idx++;
            end
            if (req_ack != '0) begin
                if (ack_exp_q.size() == 0) check("rnd_unexpected_ack", 32'(req_ack), 0);
                else check("rnd_ack", 32'(req_ack), 32'(NCH'(1) << ack_exp_q.pop_front()));
                for (int k = 0; k < NCH; k++)
                    if (req_ack[k] && words_q[k].size() > 0) void'(words_q[k].pop_front());
            end
            for (int k = 0; k < NCH; k++) begin
                req_valid[k] = (words_q[k].size() > 0);
                req_data[k*DW +: DW] = (words_q[k].size() > 0) ? words_q[k][0] : '0;
            end
            if (req_valid == '0 && !busy && exp_q.size() == 0 && ack_exp_q.size() == 0) break;
        end
        fifo_read = 1'b0;
        check("rnd_all_written", exp_q.size(), 0);
        check("rnd_all_acked", ack_exp_q.size(), 0);
        check("rnd_retry", 32'(retry_cnt), (refusals > 255) ? 255 : refusals);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
